// File: rtl/nr_divider.sv
// Iterative unsigned 32-bit divider: Newton-Raphson reciprocal refinement
// of the divisor, one multiply for the quotient estimate, then upward correction.
module nr_divider #(
    parameter int MAX_ITER = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] num,
    input  logic [31:0] den,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        div_zero
);
    localparam int CW = $clog2(MAX_ITER + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_ITER);

    typedef enum logic [2:0] {IDLE, ITER, MUL, FIX, DONE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   num_q, num_d, den_q, den_d;
    logic [33:0]   x_q, x_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0]   q_q, q_d;
    // Q never exceeds the true quotient, so R <= num and fits in 32 bits.
    logic [31:0]   r_q, r_d;
    logic          dz_q, dz_d;

    logic [4:0]    k;
    logic [33:0]   x0;
    logic [65:0]   p;
    logic [33:0]   e;
    logic [67:0]   xe;
    logic [33:0]   xn;
    logic [65:0]   nx;
    logic [31:0]   mq;
    logic [63:0]   qd;
    logic [31:0]   mr;

    always_comb begin
        k = 5'd0;
        for (int i = 0; i < 32; i++)
            if (den[i]) k = 5'(i);
    end

    // Seed 2^-(k+1) puts den*X0 in [0.5,1), the Newton convergence basin.
    assign x0      = 34'(1) << (5'd31 - k);
    assign p       = 66'(den_q) * 66'(x_q);
    assign e       = 34'(66'h2_0000_0000 - p);
    assign xe      = 68'(x_q) * 68'(e);
    assign xn      = 34'(xe >> 32);
    assign nx      = 66'(num_q) * 66'(x_q);
    assign mq      = 32'(nx >> 32);
    assign qd      = 64'(mq) * 64'(den_q);
    assign mr      = 32'(64'(num_q) - qd);
    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        den_d   = den_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: if (in_valid) begin
                num_d = num;
                den_d = den;
                cnt_d = '0;
                if (den == 32'd0) begin
                    q_d     = 32'hFFFF_FFFF;
                    r_d     = num;
                    dz_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    x_d     = x0;
                    dz_d    = 1'b0;
                    state_d = ITER;
                end
            end
            ITER: begin
                x_d   = xn;
                cnt_d = cnt_inc;
                if (xn == x_q || cnt_inc >= MAX_C) state_d = MUL;
            end
            MUL: begin
                q_d     = mq;
                r_d     = mr;
                state_d = FIX;
            end
            FIX: begin
                if (r_q >= den_q) begin
                    q_d = q_q + 32'd1;
                    r_d = r_q - den_q;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            num_q   <= '0;
            den_q   <= '0;
            x_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            den_q   <= den_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quot      = q_q;
    assign rem       = r_q;
    assign div_zero  = dz_q;
endmodule

// File: tb/tb_nr_divider.sv
// Directed bench for nr_divider: hand-computed vectors, divide-by-zero,
// backpressure, async reset mid-operation, and a short random sweep.
module tb_nr_divider;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] num = '0;
    logic [31:0] den = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_zero;

    int vectors = 0;
    int miscompares = 0;

    nr_divider #(.MAX_ITER(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .num(num), .den(den),
        .out_valid(out_valid), .out_ready(out_ready),
        .quot(quot), .rem(rem), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one operand pair; returns the cycle count until out_valid (99 = timeout).
    task automatic start_wait(input logic [31:0] n, input logic [31:0] d, output int lat);
        @(negedge clk);
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1; num = n; den = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = 99;
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready_after_release", 32'(in_ready), 32'd1);
        chk("out_valid_after_release", 32'(out_valid), 32'd0);
    endtask

    task automatic div_chk(input string tag, input logic [31:0] n, input logic [31:0] d,
                           input logic [31:0] eq, input logic [31:0] er, input logic edz);
        int lat;
        start_wait(n, d, lat);
        vectors++;
        assert (lat <= 12) else begin
            miscompares++;
            $error("FAIL %s_latency: observed %0d cycles expected <=12", tag, lat);
        end
        chk({tag, "_quot"}, quot, eq);
        chk({tag, "_rem"}, rem, er);
        chk({tag, "_dz"}, 32'(div_zero), 32'(edz));
        release_out();
    endtask

    initial begin
        int lat;
        logic [31:0] hq, hr;
        logic [31:0] rn, rd;

        // Reset state
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quot", quot, 32'd0);
        chk("rst_rem", rem, 32'd0);
        chk("rst_dz", 32'(div_zero), 32'd0);
        @(negedge clk); reset = 1'b0;

        div_chk("100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        div_chk("max_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        div_chk("1_max", 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0);
        div_chk("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        div_chk("0_9", 32'd0, 32'd9, 32'd0, 32'd0, 1'b0);
        div_chk("7_100", 32'd7, 32'd100, 32'd0, 32'd7, 1'b0);
        div_chk("pow2", 32'h8000_0000, 32'h0001_0000, 32'h0000_8000, 32'd0, 1'b0);

        // Divide by zero: result on the first cycle after accept
        start_wait(32'd5, 32'd0, lat);
        chk("dz_latency", 32'(lat), 32'd1);
        chk("dz_quot", quot, 32'hFFFF_FFFF);
        chk("dz_rem", rem, 32'd5);
        chk("dz_flag", 32'(div_zero), 32'd1);
        release_out();

        // Backpressure: 1234567/89 = 13871 r 48, held with stray in_valid pulses
        start_wait(32'd1234567, 32'd89, lat);
        chk("bp_latency_ok", 32'(lat <= 12), 32'd1);
        hq = quot; hr = rem;
        chk("bp_quot", hq, 32'd13871);
        chk("bp_rem", hr, 32'd48);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = c[0]; num = 32'd77; den = 32'd3;
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_quot_stable", quot, hq);
            chk("bp_rem_stable", rem, hr);
        end
        @(negedge clk); in_valid = 1'b0;
        release_out();

        // Async reset in the middle of ITER
        @(negedge clk);
        in_valid = 1'b1; num = 32'd1000; den = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("arst_no_output", 32'(out_valid), 32'd0);
        div_chk("1000_3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

        // Random sweep against the language's own / and %
        for (int t = 0; t < 200; t++) begin
            rn = $urandom;
            case (t % 4)
                0: rd = $urandom;
                1: rd = $urandom_range(1, 255);
                2: rd = $urandom >> $urandom_range(0, 31);
                default: rd = 32'd1 << $urandom_range(0, 31);
            endcase
            if (rd == 32'd0) rd = 32'd1;
            div_chk("rand", rn, rd, rn / rd, rn % rd, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
